streaming_bot_feeder: RTL and testbench

Transmit-side companion of the streaming count-connected core. Accepts leaf-eliminated graphs from an upstream valid/ready source, drives them into the core's input port while honouring its `slowDownInput` backpressure, and consumes the core's result stream. Accumulates the per-batch sum of `2^connectCount` and signals batch completion once every issued graph of the batch has returned.

---
 rtl/streaming_bot_feeder.sv | 193 +++++++++++++++++++
 tb/tb_streaming_bot_feeder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/streaming_bot_feeder.sv
// ============================================================================
// streaming_bot_feeder
//
// Transmit-side companion of the streaming count-connected core. Takes
// leaf-eliminated graphs from an upstream valid/ready source and pushes them
// into the core one per cycle, backing off while the core's input FIFO
// reports almost-full. It also consumes the core's result stream,
// accumulating the sum of 2^connectCount over the batch. It pulses batchDone
// once every graph issued for the batch has come back.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   graphValid        upstream graph available
//   graphIn           upstream graph (128 bits)
//   tagIn             upstream sideband tag carried through the core
//   lastInBatch       marks graphIn as the final graph of the batch
//   graphReady        feeder accepts graphIn this cycle
//   isBotValid        one-cycle strobe into the core
//   graphOut          graph presented to the core
//   extraDataOut      sideband tag presented to the core
//   slowDownInput     core input FIFO almost full
//   resultValid       core result strobe
//   connectCount      core result value
//   batchSum          sum of 2^connectCount over the batch
//   batchCount        number of results received in the batch
//   batchDone         one-cycle pulse when the batch has fully returned
//   busy              a batch is in progress
//   overflow          sticky: the sum accumulator overflowed
//   protocolError     sticky: result arrived with nothing outstanding
// ============================================================================
module streaming_bot_feeder #(
    parameter int EXTRA_DATA_WIDTH  = 1,
    parameter int SUM_WIDTH         = 48,
    parameter int OUTSTANDING_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           graphValid,
    input  logic [127:0]                   graphIn,
    input  logic [EXTRA_DATA_WIDTH-1:0]    tagIn,
    input  logic                           lastInBatch,
    output logic                           graphReady,
    output logic                           isBotValid,
    output logic [127:0]                   graphOut,
    output logic [EXTRA_DATA_WIDTH-1:0]    extraDataOut,
    input  logic                           slowDownInput,
    input  logic                           resultValid,
    input  logic [5:0]                     connectCount,
    output logic [SUM_WIDTH-1:0]           batchSum,
    output logic [OUTSTANDING_WIDTH+5:0]   batchCount,
    output logic                           batchDone,
    output logic                           busy,
    output logic                           overflow,
    output logic                           protocolError
);

    localparam int COUNT_WIDTH = OUTSTANDING_WIDTH + 6;
    localparam logic [OUTSTANDING_WIDTH-1:0] OUTSTANDING_ONE = {{(OUTSTANDING_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0]       COUNT_ONE       = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SUM_WIDTH-1:0]         SUM_ONE         = {{(SUM_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } FeederState;

    FeederState state;
    FeederState nextState;

    logic                          slowDownReg;
    logic                          accept;
    logic                          idleAccept;
    logic                          orphanResult;
    logic                          termOutOfRange;
    logic                          sumCarry;
    logic [OUTSTANDING_WIDTH-1:0]  outstanding;
    logic [OUTSTANDING_WIDTH-1:0]  outstandingBase;
    logic [OUTSTANDING_WIDTH-1:0]  outstandingNext;
    logic [SUM_WIDTH-1:0]          sumBase;
    logic [SUM_WIDTH-1:0]          sumTerm;
    logic [SUM_WIDTH-1:0]          sumNext;
    logic [COUNT_WIDTH-1:0]        countBase;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. DRAIN exits on the same cycle the last result is
    // consumed so that IDLE and batchDone both appear one cycle later.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = lastInBatch ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (accept && lastInBatch) begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (outstandingNext == '0) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // FSM outputs. Backpressure uses the registered slowDownInput; the
    // core FIFO's almost-full margin absorbs the one-cycle lag.
    always_comb begin
        graphReady = (state == IDLE || state == STREAM) && !slowDownReg && !rst;
        busy       = (state != IDLE);
    end

    // Accounting arithmetic. An accept in IDLE starts a new batch, so the
    // counters are treated as zero before this cycle's accept/result are
    // applied. A result with nothing outstanding is flagged and does not
    // decrement, so the counter never wraps below zero.
    always_comb begin
        accept          = graphValid && graphReady;
        idleAccept      = accept && (state == IDLE);
        outstandingBase = idleAccept ? '0 : outstanding;
        orphanResult    = resultValid && !accept && (outstandingBase == '0);

        outstandingNext = outstandingBase;
        if (accept && !resultValid) begin
            outstandingNext = outstandingBase + OUTSTANDING_ONE;
        end else if (!accept && resultValid && !orphanResult) begin
            outstandingNext = outstandingBase - OUTSTANDING_ONE;
        end

        // A shift past the accumulator width contributes nothing but is
        // still reported as an overflow.
        termOutOfRange = (32'(connectCount) >= 32'(SUM_WIDTH));
        sumTerm        = termOutOfRange ? '0 : (SUM_ONE << connectCount);
        sumBase        = idleAccept ? '0 : batchSum;
        {sumCarry, sumNext} = {1'b0, sumBase} + {1'b0, sumTerm};
        countBase      = idleAccept ? '0 : batchCount;
    end

    // Datapath registers: core-side handshake, counters, sticky flags and
    // the batch-complete pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            slowDownReg   <= 1'b0;
            isBotValid    <= 1'b0;
            graphOut      <= '0;
            extraDataOut  <= '0;
            outstanding   <= '0;
            batchSum      <= '0;
            batchCount    <= '0;
            batchDone     <= 1'b0;
            overflow      <= 1'b0;
            protocolError <= 1'b0;
        end else begin
            slowDownReg <= slowDownInput;
            isBotValid  <= accept;
            if (accept) begin
                graphOut     <= graphIn;
                extraDataOut <= tagIn;
            end

            outstanding <= outstandingNext;

            if (resultValid) begin
                batchSum   <= sumNext;
                batchCount <= countBase + COUNT_ONE;
                if (termOutOfRange || sumCarry) begin
                    overflow <= 1'b1;
                end
                if (orphanResult) begin
                    protocolError <= 1'b1;
                end
            end else if (idleAccept) begin
                batchSum   <= '0;
                batchCount <= '0;
            end

            batchDone <= (state == DRAIN) && (outstandingNext == '0);
        end
    end

endmodule

// File: tb/tb_streaming_bot_feeder.sv
// ============================================================================
// tb_streaming_bot_feeder
//
// Directed bench for streaming_bot_feeder. Inputs are driven 1 time unit
// after each rising edge and outputs are sampled at that same point, so
// every observation reflects the registers updated by the preceding edge.
// ============================================================================
module tb_streaming_bot_feeder;

    localparam int EDW = 8;
    localparam int SW  = 48;
    localparam int OW  = 10;

    logic            clk;
    logic            rst;
    logic            graphValid;
    logic [127:0]    graphIn;
    logic [EDW-1:0]  tagIn;
    logic            lastInBatch;
    logic            graphReady;
    logic            isBotValid;
    logic [127:0]    graphOut;
    logic [EDW-1:0]  extraDataOut;
    logic            slowDownInput;
    logic            resultValid;
    logic [5:0]      connectCount;
    logic [SW-1:0]   batchSum;
    logic [OW+5:0]   batchCount;
    logic            batchDone;
    logic            busy;
    logic            overflow;
    logic            protocolError;

    int checks = 0;
    int errors = 0;

    streaming_bot_feeder #(
        .EXTRA_DATA_WIDTH (EDW),
        .SUM_WIDTH        (SW),
        .OUTSTANDING_WIDTH(OW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .graphValid   (graphValid),
        .graphIn      (graphIn),
        .tagIn        (tagIn),
        .lastInBatch  (lastInBatch),
        .graphReady   (graphReady),
        .isBotValid   (isBotValid),
        .graphOut     (graphOut),
        .extraDataOut (extraDataOut),
        .slowDownInput(slowDownInput),
        .resultValid  (resultValid),
        .connectCount (connectCount),
        .batchSum     (batchSum),
        .batchCount   (batchCount),
        .batchDone    (batchDone),
        .busy         (busy),
        .overflow     (overflow),
        .protocolError(protocolError)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mkGraph(input logic [7:0] t);
        return {16'hBEEF, 104'd0, t};
    endfunction

    // Drive one cycle of upstream/core inputs, then return them to idle.
    task automatic applyStimulus(input logic gv, input logic [7:0] t, input logic last,
                                 input logic rv, input logic [5:0] cc);
        graphValid   = gv;
        graphIn      = mkGraph(t);
        tagIn        = t;
        lastInBatch  = last;
        resultValid  = rv;
        connectCount = cc;
        tick();
        graphValid   = 1'b0;
        graphIn      = '0;
        tagIn        = '0;
        lastInBatch  = 1'b0;
        resultValid  = 1'b0;
        connectCount = '0;
    endtask

    initial begin
        int expTag;
        int seenValid;
        int nextTag;
        logic sawDone;

        rst           = 1'b1;
        graphValid    = 1'b0;
        graphIn       = '0;
        tagIn         = '0;
        lastInBatch   = 1'b0;
        slowDownInput = 1'b0;
        resultValid   = 1'b0;
        connectCount  = '0;

        // ---------------- reset state ----------------
        #1;
        repeat (3) tick();
        checkOutput("rstReady",    graphReady,    1'b0);
        checkOutput("rstBusy",     busy,          1'b0);
        checkOutput("rstBotValid", isBotValid,    1'b0);
        checkOutput("rstSum",      batchSum,      '0);
        checkOutput("rstOverflow", overflow,      1'b0);
        checkOutput("rstProtoErr", protocolError, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("readyAfterRst", graphReady, 1'b1);

        // ---------------- single batch ----------------
        applyStimulus(1'b1, 8'd1, 1'b0, 1'b0, 6'd0);
        checkOutput("sbBotValid", isBotValid,   1'b1);
        checkOutput("sbGraphOut", graphOut,     mkGraph(8'd1));
        checkOutput("sbTagOut",   extraDataOut, 8'd1);
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 6'd0);
        applyStimulus(1'b1, 8'd3, 1'b1, 1'b0, 6'd0);
        checkOutput("sbReadyDrain", graphReady, 1'b0);
        repeat (512) tick();
        checkOutput("sbBotValidLow", isBotValid, 1'b0);
        checkOutput("sbGraphHold",   graphOut,   mkGraph(8'd3));
        checkOutput("sbBusy",        busy,       1'b1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd1);
        checkOutput("sbSum1",   batchSum,   48'd2);
        checkOutput("sbCount1", batchCount, 16'd1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd2);
        checkOutput("sbDoneEarly", batchDone, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd3);
        checkOutput("sbDone",   batchDone,  1'b1);
        checkOutput("sbSum",    batchSum,   48'd14);
        checkOutput("sbCount",  batchCount, 16'd3);
        checkOutput("sbIdle",   busy,       1'b0);
        checkOutput("sbReady",  graphReady, 1'b1);
        tick();
        checkOutput("sbDonePulse", batchDone, 1'b0);
        checkOutput("sbSumHold",   batchSum,  48'd14);

        // ---------------- backpressure ----------------
        expTag    = 0;
        seenValid = 0;
        nextTag   = 0;
        for (int c = 0; c < 40; c++) begin
            logic accepted;
            slowDownInput = (c >= 10 && c < 30);
            graphValid    = 1'b1;
            tagIn         = 8'(nextTag);
            graphIn       = mkGraph(8'(nextTag));
            lastInBatch   = 1'b0;
            if (c == 0 || c == 10 || c == 11 || c == 30 || c == 31) begin
                checkOutput($sformatf("bpReady%0d", c), graphReady, !(c >= 11 && c <= 30));
            end
            accepted = graphReady;
            if (accepted) nextTag++;
            tick();
            if (isBotValid) seenValid++;
            if (accepted) begin
                checkOutput("bpTag", extraDataOut, 8'(expTag));
                expTag++;
            end
        end
        graphValid    = 1'b0;
        slowDownInput = 1'b0;
        checkOutput("bpAccepts", 128'(seenValid), 128'd20);
        applyStimulus(1'b1, 8'd20, 1'b1, 1'b0, 6'd0);
        checkOutput("bpLastTag", extraDataOut, 8'd20);
        for (int i = 0; i < 21; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd0);
        checkOutput("bpDone",  batchDone,  1'b1);
        checkOutput("bpSum",   batchSum,   48'd21);
        checkOutput("bpCount", batchCount, 16'd21);

        // ---------------- simultaneous accept and result ----------------
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 6'd0);
        checkOutput("simClearSum",   batchSum,   '0);
        checkOutput("simClearCount", batchCount, '0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 6'd0);
        checkOutput("simOutPre", dut.outstanding, 10'd5);
        applyStimulus(1'b1, 8'd0, 1'b1, 1'b1, 6'd4);
        checkOutput("simOutSame", dut.outstanding, 10'd5);
        checkOutput("simSum",     batchSum,        48'd16);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd0);
        checkOutput("simNotDone", batchDone, 1'b0);
        checkOutput("simBusy",    busy,      1'b1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd0);
        checkOutput("simDone",  batchDone,  1'b1);
        checkOutput("simSumF",  batchSum,   48'd21);
        checkOutput("simCount", batchCount, 16'd6);

        // ---------------- overflow: out-of-range shift ----------------
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 6'd0);
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 6'd0);
        applyStimulus(1'b1, 8'd0, 1'b1, 1'b0, 6'd0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd48);
        checkOutput("ovfShift",    overflow,   1'b1);
        checkOutput("ovfShiftSum", batchSum,   '0);
        checkOutput("ovfShiftCnt", batchCount, 16'd1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd0);
        checkOutput("ovfSticky", overflow, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd0);
        checkOutput("ovfShiftDone", batchDone, 1'b1);
        checkOutput("ovfShiftSumF", batchSum,  48'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("ovfClearRst", overflow, 1'b0);

        // ---------------- overflow: carry out ----------------
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 6'd0);
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 6'd0);
        applyStimulus(1'b1, 8'd0, 1'b1, 1'b0, 6'd0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd47);
        checkOutput("carrySum1", batchSum, 48'h8000_0000_0000);
        checkOutput("carryNone", overflow, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd47);
        checkOutput("carrySum2", batchSum, '0);
        checkOutput("carryOvf",  overflow, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd0);
        checkOutput("carryDone", batchDone, 1'b1);
        checkOutput("carrySumF", batchSum,  48'd1);

        // ---------------- protocol error ----------------
        tick();
        checkOutput("peBefore", protocolError, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd2);
        checkOutput("peFlag",   protocolError,   1'b1);
        checkOutput("peOutZero", dut.outstanding, 10'd0);
        checkOutput("peSum",    batchSum,        48'd5);
        checkOutput("peIdle",   busy,            1'b0);

        // ---------------- reset mid-batch ----------------
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 6'd0);
        checkOutput("midBusy", busy, 1'b1);
        rst = 1'b1;
        tick();
        checkOutput("midReady",    graphReady,    1'b0);
        checkOutput("midBotValid", isBotValid,    1'b0);
        checkOutput("midGraphOut", graphOut,      '0);
        checkOutput("midTagOut",   extraDataOut,  '0);
        checkOutput("midSum",      batchSum,      '0);
        checkOutput("midCount",    batchCount,    '0);
        checkOutput("midBusyOff",  busy,          1'b0);
        checkOutput("midOverflow", overflow,      1'b0);
        checkOutput("midProtoErr", protocolError, 1'b0);
        rst = 1'b0;
        sawDone = batchDone;
        repeat (3) begin
            tick();
            sawDone = sawDone | batchDone;
        end
        checkOutput("midNoDone", sawDone, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd1);
        checkOutput("midLateResult", protocolError, 1'b1);
        applyStimulus(1'b1, 8'd7, 1'b1, 1'b0, 6'd0);
        checkOutput("freshTag", extraDataOut, 8'd7);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 6'd5);
        checkOutput("freshDone",  batchDone,  1'b1);
        checkOutput("freshSum",   batchSum,   48'd32);
        checkOutput("freshCount", batchCount, 16'd1);
        checkOutput("freshIdle",  busy,       1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
